// File: rtl/unaligned_read_gather_pkg.sv
// unaligned_read_gather_pkg: shared bank geometry, FSM states and bank address array type
package unaligned_read_gather_pkg;
   localparam int NBANKS = 16;
   localparam int OFF_W = 4;
   localparam int BANK_ROW_W = 16;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef logic [NBANKS-1:0][BANK_ROW_W-1:0] bank_addr_t;
endpackage

// File: rtl/unaligned_read_gather_byte_lane_rotator.sv
// byte_lane_rotator: combinational 16x8-bit right-rotate, out byte k = in byte (k+amt) mod 16
module byte_lane_rotator
   import unaligned_read_gather_pkg::*;
(
   input  logic [NBANKS*8-1:0] din,
   input  logic [OFF_W-1:0]    amt,
   output logic [NBANKS*8-1:0] dout
);
   for (genvar k = 0; k < NBANKS; k++) begin : g_lane
      assign dout[8*k +: 8] = din[{4'(k) + amt, 3'b000} +: 8];
   end
endmodule

// File: rtl/unaligned_read_gather.sv
// unaligned_read_gather: turns one byte-addressed 128-bit read into per-bank row reads and a rotated response
module unaligned_read_gather
   import unaligned_read_gather_pkg::*;
#(
   parameter int ROW_W = 16,
   parameter int RAM_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ROW_W+3:0]          req_addr,
   output logic [NBANKS-1:0]         bank_re,
   output logic [NBANKS*ROW_W-1:0]   bank_addr,
   input  logic [NBANKS*8-1:0]       bank_q,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [NBANKS*8-1:0]       resp_data
);
   state_t state;
   logic [OFF_W-1:0] off;
   logic [1:0] cnt;
   logic [NBANKS-1:0][ROW_W-1:0] addr_q, addr_d;
   logic [NBANKS*8-1:0] rot;
   // banks below the offset hold the bytes that spill into the next row
   for (genvar b = 0; b < NBANKS; b++) begin : g_addr
      assign addr_d[b] = (4'(b) < req_addr[3:0]) ? req_addr[ROW_W+3:4] + ROW_W'(1) : req_addr[ROW_W+3:4];
   end
   byte_lane_rotator u_rot (.din(bank_q), .amt(off), .dout(rot));
   assign req_ready = state == IDLE;
   assign resp_valid = state == RESP;
   assign bank_addr = addr_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         off <= '0;
         cnt <= '0;
         addr_q <= '0;
         bank_re <= '0;
         resp_data <= '0;
      end else begin
         unique case (state)
            IDLE: if (req_valid) begin
               off <= req_addr[3:0];
               addr_q <= addr_d;
               bank_re <= '1;
               state <= ISSUE;
            end
            ISSUE: begin
               bank_re <= '0;
               cnt <= 2'(RAM_LAT - 1);
               state <= WAIT;
            end
            WAIT: if (cnt == 2'd0) begin
               resp_data <= rot;
               state <= RESP;
            end else cnt <= cnt - 1'b1;
            RESP: if (resp_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_unaligned_read_gather.sv
// tb_unaligned_read_gather: table vectors, corner sequences and random reads on RAM_LAT=1,2,3 instances
module tb_unaligned_read_gather;
   import unaligned_read_gather_pkg::*;
   logic clk = 0;
   logic rst = 1;
   int cyc = 0;
   logic req_valid [3];
   logic req_ready [3];
   logic [19:0] req_addr [3];
   logic [15:0] bank_re [3];
   bank_addr_t bank_addr [3];
   logic [127:0] bank_q [3];
   logic resp_valid [3];
   logic resp_ready [3];
   logic [127:0] resp_data [3];
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [7:0] mem_byte(input logic [19:0] a);
      return a[7:0] + 8'(a[15:8] * 3) + 8'(a[19:16] * 7);
   endfunction
   function automatic logic [127:0] exp_data(input logic [19:0] a);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = mem_byte(a + 20'(k));
      return r;
   endfunction
   // bank b serves whichever of the 16 consecutive bytes lands in it
   function automatic bank_addr_t exp_ba(input logic [19:0] a);
      bank_addr_t r;
      logic [19:0] x;
      for (int b = 0; b < 16; b++) begin
         x = a + 20'((b - int'(a[3:0])) & 15);
         r[b] = x[19:4];
      end
      return r;
   endfunction
   for (genvar i = 0; i < 3; i++) begin : g
      logic [127:0] pipe [4];
      unaligned_read_gather #(.ROW_W(16), .RAM_LAT(i + 1)) dut (
         .clk(clk), .rst(rst), .req_valid(req_valid[i]), .req_ready(req_ready[i]),
         .req_addr(req_addr[i]), .bank_re(bank_re[i]), .bank_addr(bank_addr[i]),
         .bank_q(bank_q[i]), .resp_valid(resp_valid[i]), .resp_ready(resp_ready[i]),
         .resp_data(resp_data[i]));
      always @(posedge clk) begin
         for (int b = 0; b < 16; b++)
            pipe[0][8*b +: 8] <= bank_re[i][b] ? mem_byte({bank_addr[i][b], 4'(b)}) : 8'hEE;
         for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
      end
      assign bank_q[i] = pipe[i];
   end
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   // call at a negedge; returns at the negedge where resp_valid is first seen
   task automatic txn(input int d, input logic [19:0] a, output logic [127:0] data, output int lat, output int t_acc);
      int n = 0;
      req_addr[d] = a;
      req_valid[d] = 1;
      resp_ready[d] = 1;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", req_ready[d], 1);
      @(posedge clk);
      #1 t_acc = cyc;
      req_valid[d] = 0;
      @(negedge clk);
      check("issue_re", bank_re[d], 16'hFFFF);
      check("bank_addr", bank_addr[d], exp_ba(a));
      @(negedge clk);
      lat = 1;
      check("re_drop", bank_re[d], 0);
      while (!resp_valid[d] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      data = resp_data[d];
   endtask
   typedef struct {
      int d;
      logic [19:0] addr;
      logic [127:0] data;
      logic [15:0] ba0;
      logic [15:0] ba15;
   } vec_t;
   vec_t tbl [5];
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      logic [127:0] data, snap;
      logic [19:0] a;
      int lat, t, n;
      int acc [3];
      tbl[0] = '{0, 20'h00010, 128'h1F1E1D1C1B1A19181716151413121110, 16'h0001, 16'h0001};
      tbl[1] = '{0, 20'h0001A, 128'h292827262524232221201F1E1D1C1B1A, 16'h0002, 16'h0001};
      tbl[2] = '{0, 20'hFFFFF, 128'h0E0D0C0B0A0908070605040302010065, 16'h0000, 16'hFFFF};
      tbl[3] = '{1, 20'h00010, 128'h1F1E1D1C1B1A19181716151413121110, 16'h0001, 16'h0001};
      tbl[4] = '{2, 20'h0001A, 128'h292827262524232221201F1E1D1C1B1A, 16'h0002, 16'h0001};
      for (int d = 0; d < 3; d++) begin
         req_valid[d] = 0;
         req_addr[d] = '0;
         resp_ready[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("rst_req_ready", req_ready[d], 1);
         check("rst_bank_re", bank_re[d], 0);
         check("rst_bank_addr", bank_addr[d], 0);
         check("rst_resp_valid", resp_valid[d], 0);
         check("rst_resp_data", resp_data[d], 0);
      end
      for (int v = 0; v < 5; v++) begin
         txn(tbl[v].d, tbl[v].addr, data, lat, t);
         check("vec_ba0", bank_addr[tbl[v].d][0], tbl[v].ba0);
         check("vec_ba15", bank_addr[tbl[v].d][15], tbl[v].ba15);
         check("vec_latency", lat, tbl[v].d + 2);
         check("vec_data", data, tbl[v].data);
         check("vec_data_model", data, exp_data(tbl[v].addr));
         repeat (2) @(negedge clk);
      end
      check("ba9_off10", bank_addr[2][9], 16'h0002);
      check("ba10_off10", bank_addr[2][10], 16'h0001);
      // backpressure: response frozen, second request refused
      a = 20'h3C5A7;
      req_addr[0] = a;
      req_valid[0] = 1;
      resp_ready[0] = 0;
      @(posedge clk);
      #1 req_valid[0] = 0;
      n = 0;
      while (!resp_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid", resp_valid[0], 1);
      snap = resp_data[0];
      check("bp_data", snap, exp_data(a));
      req_addr[0] = 20'h01234;
      req_valid[0] = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_hold_valid", resp_valid[0], 1);
         check("bp_hold_data", resp_data[0], snap);
         check("bp_req_ready", req_ready[0], 0);
      end
      resp_ready[0] = 1;
      req_valid[0] = 0;
      @(negedge clk);
      check("bp_release_ready", req_ready[0], 1);
      check("bp_release_valid", resp_valid[0], 0);
      check("bp_no_second", bank_re[0], 0);
      repeat (2) @(negedge clk);
      // reset during WAIT on the RAM_LAT=3 instance
      req_addr[2] = 20'h0ABCD;
      req_valid[2] = 1;
      resp_ready[2] = 1;
      @(posedge clk);
      #1 req_valid[2] = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("mid_rst_ready", req_ready[2], 1);
      check("mid_rst_valid", resp_valid[2], 0);
      check("mid_rst_re", bank_re[2], 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("mid_rst_no_resp", resp_valid[2], 0);
      end
      txn(2, 20'h0ABCD, data, lat, t);
      check("post_rst_data", data, exp_data(20'h0ABCD));
      repeat (2) @(negedge clk);
      // back-to-back on RAM_LAT=2 at offsets 0, 7, 15
      for (int j = 0; j < 3; j++) begin
         a = 20'h12340 | 20'(j == 0 ? 0 : j == 1 ? 7 : 15);
         txn(1, a, data, lat, acc[j]);
         check("b2b_data", data, exp_data(a));
         check("b2b_latency", lat, 3);
         if (j > 0) check("b2b_spacing", acc[j] - acc[j-1], 5);
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         for (int r = 0; r < 8; r++) begin
            a = 20'($urandom);
            txn(d, a, data, lat, t);
            check("rand_data", data, exp_data(a));
            check("rand_latency", lat, d + 2);
         end
         repeat (2) @(negedge clk);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
